// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - 8x16 register file, two async read ports, one sync write port, write-to-read bypass
module regfile_bypass #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int SELW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SELW-1:0]  read1RegSel,
    input  logic [SELW-1:0]  read2RegSel,
    input  logic [SELW-1:0]  writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic             writeEn,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    output logic             err
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic             err_q;
    logic             err_d;
    logic             first_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeEn) begin
            regs_q[writeRegSel] <= writeData;
        end
    end

    // first_q marks the first edge after reset release; a write there is flagged but still commits
    always_comb begin
        err_d = err_q;
        if (first_q && writeEn) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            err_q   <= err_d;
            first_q <= 1'b0;
        end
    end

    // Bypass stays live during reset so a matching read sees writeData
    assign read1Data = (writeEn && (writeRegSel == read1RegSel)) ? writeData : regs_q[read1RegSel];
    assign read2Data = (writeEn && (writeRegSel == read2RegSel)) ? writeData : regs_q[read2RegSel];
    assign err       = err_q;

endmodule

// File: tb/tb_regfile_bypass.sv
// tb/tb_regfile_bypass.sv - directed self-checking bench for regfile_bypass
module tb_regfile_bypass;

    logic        clk;
    logic        rst;
    logic [2:0]  read1RegSel;
    logic [2:0]  read2RegSel;
    logic [2:0]  writeRegSel;
    logic [15:0] writeData;
    logic        writeEn;
    logic [15:0] read1Data;
    logic [15:0] read2Data;
    logic        err;

    int n_checks;
    int n_pass;

    regfile_bypass dut (
        .clk         (clk),
        .rst         (rst),
        .read1RegSel (read1RegSel),
        .read2RegSel (read2RegSel),
        .writeRegSel (writeRegSel),
        .writeData   (writeData),
        .writeEn     (writeEn),
        .read1Data   (read1Data),
        .read2Data   (read2Data),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] sel, input logic [15:0] data);
        writeEn     = 1'b1;
        writeRegSel = sel;
        writeData   = data;
        step();
        writeEn     = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        writeEn     = 1'b0;
        writeRegSel = 3'd0;
        writeData   = 16'h0000;
        read1RegSel = 3'd0;
        read2RegSel = 3'd7;

        step();
        step();
        check("reset_r1", read1Data, 16'h0000);
        check("reset_r2", read2Data, 16'h0000);
        check("reset_err", {15'd0, err}, 16'h0000);
        rst = 1'b0;
        step();

        // Write/readback sweep
        for (int i = 0; i < 8; i++) begin
            write_reg(3'(i), 16'(16'h1111 * (i + 1)));
        end
        for (int i = 0; i < 8; i++) begin
            read1RegSel = 3'(i);
            read2RegSel = 3'(7 - i);
            #1;
            check($sformatf("sweep_p1_r%0d", i), read1Data, 16'(16'h1111 * (i + 1)));
            check($sformatf("sweep_p2_r%0d", 7 - i), read2Data, 16'(16'h1111 * (8 - i)));
        end

        // Async reset clear with no clock edge
        write_reg(3'd3, 16'hBEEF);
        read1RegSel = 3'd3;
        #1;
        check("preload_r3", read1Data, 16'hBEEF);
        rst = 1'b1;
        #2;
        check("async_clr_r3", read1Data, 16'h0000);
        rst = 1'b0;
        #1;
        check("after_clr_r3", read1Data, 16'h0000);
        check("after_clr_err", {15'd0, err}, 16'h0000);
        step();

        // Bypass
        write_reg(3'd2, 16'h1234);
        write_reg(3'd4, 16'h4444);
        writeEn     = 1'b1;
        writeRegSel = 3'd2;
        writeData   = 16'hABCD;
        read1RegSel = 3'd2;
        read2RegSel = 3'd4;
        #1;
        check("bypass_p1", read1Data, 16'hABCD);
        check("bypass_p2_old", read2Data, 16'h4444);
        step();
        writeEn = 1'b0;
        #1;
        check("bypass_stored", read1Data, 16'hABCD);

        // Dual same-select
        write_reg(3'd6, 16'h00FF);
        read1RegSel = 3'd6;
        read2RegSel = 3'd6;
        #1;
        check("dual_p1", read1Data, 16'h00FF);
        check("dual_p2", read2Data, 16'h00FF);
        writeEn     = 1'b1;
        writeRegSel = 3'd6;
        writeData   = 16'h7F00;
        #1;
        check("dual_byp_p1", read1Data, 16'h7F00);
        check("dual_byp_p2", read2Data, 16'h7F00);
        step();
        writeEn = 1'b0;
        #1;
        check("dual_stored_p1", read1Data, 16'h7F00);

        // Write during reset is discarded, bypass still live
        write_reg(3'd1, 16'h2222);
        rst         = 1'b1;
        writeEn     = 1'b1;
        writeRegSel = 3'd1;
        writeData   = 16'h5555;
        read1RegSel = 3'd1;
        #1;
        check("rst_bypass", read1Data, 16'h5555);
        step();
        writeEn = 1'b0;
        #1;
        check("rst_write_lost", read1Data, 16'h0000);
        rst = 1'b0;
        step();
        check("rst_write_lost_post", read1Data, 16'h0000);
        check("rst_no_err", {15'd0, err}, 16'h0000);

        // Normal write on second edge after release does not set err
        write_reg(3'd0, 16'h0F0F);
        check("late_write_no_err", {15'd0, err}, 16'h0000);

        // err flag: write held as rst falls
        rst = 1'b1;
        step();
        writeEn     = 1'b1;
        writeRegSel = 3'd5;
        writeData   = 16'hCAFE;
        rst         = 1'b0;
        #1;
        check("err_before_edge", {15'd0, err}, 16'h0000);
        step();
        writeEn     = 1'b0;
        read1RegSel = 3'd5;
        #1;
        check("err_set", {15'd0, err}, 16'h0001);
        check("err_write_commit", read1Data, 16'hCAFE);
        write_reg(3'd7, 16'h1357);
        step();
        check("err_sticky", {15'd0, err}, 16'h0001);
        rst = 1'b1;
        #1;
        check("err_cleared", {15'd0, err}, 16'h0000);
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

8-entry × 16-bit register file with two asynchronous read ports, one synchronous write port, and write-to-read bypass. It sits directly downstream of the 4:1 16-bit writeback select mux: that mux's output drives `writeData`. `read1Data` and `read2Data` feed the decode-stage operand path. The bypass lets an instruction read a register in the same cycle it is written back, with no stall.

## Interface
- `WIDTH`, 16, data width of each register and of every data port.
- `NREGS`, 8, number of registers; select width is log2(`NREGS`) = 3.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears every register while high.
- `read1RegSel`  in  3  register index for read port 1.
- `read2RegSel`  in  3  register index for read port 2.
- `writeRegSel`  in  3  register index for the write port.
- `writeData`  in  `WIDTH`  write value, driven by the 4:1 writeback mux.
- `writeEn`  in  1  write enable; the write commits at the next rising edge.
- `read1Data`  out  `WIDTH`  read port 1 value (combinational).
- `read2Data`  out  `WIDTH`  read port 2 value (combinational).
- `err`  out  1  registered flag: a write was attempted during the cycle in which `rst` deasserted.

## Operation
- Storage:
  - `NREGS` registers of `WIDTH` bits, built from async-reset flops.
  - All registers are general purpose; R0 is not hardwired.
- Write:
  - At a rising `clk` with `writeEn`=1 and `rst`=0, `reg[writeRegSel]` ← `writeData`.
  - Every other register holds its value.
  - With `writeEn`=0, no register changes.
- Read, for each port p independently:
  - If `writeEn`=1 and `writeRegSel`==`readpRegSel`, then `readpData` = `writeData` (bypass).
  - Otherwise `readpData` = `reg[readpRegSel]`.
- Both ports may select the same register. Both then return the same value, bypassed or stored.
- Reset:
  - While `rst`=1, all registers read 0.
  - A pending write at a rising edge is discarded.
  - The bypass path stays active: a matching read still returns `writeData`, not 0.
- `err`:
  - Set at the first rising edge after `rst` falls if `writeEn`=1 on that edge.
  - That write does commit.
  - Cleared by `rst`; otherwise sticky.

## Timing
- Read latency: 0 cycles. Outputs follow the select/data inputs combinationally.
- Write latency: 1 cycle. The value is visible from storage starting the cycle after the edge, and through the bypass during the write cycle itself.
- Write then read of the same register:
  - Cycle N: bypassed value.
  - Cycle N+1 onward: stored value (equal).
- Reset values:
  - All registers: 0x0000.
  - `read1Data`/`read2Data`: 0x0000 unless bypassing.
  - `err`: 0.
- `rst` asserted mid-operation: registers clear immediately, with no clock edge needed. An in-flight write is lost.
- `rst` released between clock edges: the next rising edge is a normal write edge.
- Back-to-back writes to the same register: last write wins. No hazard.
- Simultaneous write and read of different registers: the read returns the old stored value of its own register, unaffected by the write.

## Test plan
- **Reset clear:** preload R3=0xBEEF. Pulse `rst` high for half a cycle with no clock edge. Required: `read1Data`=0x0000 with `read1RegSel`=3, `err`=0.
- **Write/readback:** write R0..R7 with 0x1111×(i+1) on consecutive edges. Then, with `writeEn`=0, sweep both ports. Required: each index returns its value, e.g. R5=0x6666.
- **Bypass:** R2=0x1234 stored. Drive `writeEn`=1, `writeRegSel`=2, `writeData`=0xABCD, `read1RegSel`=2, `read2RegSel`=4. Required, same cycle: `read1Data`=0xABCD and `read2Data`=R4 (old value). After the edge, `writeEn`=0 gives `read1Data`=0xABCD.
- **Dual same-select:** both read selects=6 with R6=0x00FF. Required: both outputs 0x00FF. Then write R6=0x7F00 with both ports bypassing. Required: both outputs 0x7F00 in the write cycle.
- **Write during reset:** `rst`=1, `writeEn`=1, R1←0x5555 across an edge. Required: R1 reads 0x0000 after `rst` falls.
- **err flag:** hold `writeEn`=1 as `rst` falls. Required: `err`=1 after the next edge, R(sel) holds the written value, and `err` stays 1 until `rst` is reasserted.
